// File: rtl/bcd_serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl_pkg
// Shared definitions for the serial BCD arithmetic controllers. The adder
// controller uses them now, and the planned subtractor controller will use
// them too.
//   state_t        : controller FSM encodings (IDLE, ADD, DONE)
//   BCD_MAX        : largest legal BCD digit value
//   digit_invalid(): true when a nibble is not a legal BCD digit
// ---------------------------------------------------------------------------
package bcd_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic digit_invalid(input logic [3:0] digit);
        return digit > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl_if
// Handshake and operand/result bundle between the calculator front end
// (master) and the serial BCD adder controller (slave).
//   start        : request; the controller accepts it when idle or done
//   a, b, cin    : packed BCD operands (digit 0 in bits [3:0]) and carry-in
//   busy         : digits are being processed
//   done         : one-cycle pulse when sum/cout/err become valid
//   sum/cout/err : packed BCD result, decimal carry-out, invalid-digit flag
// ---------------------------------------------------------------------------
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl_bcdadd.sv
// ---------------------------------------------------------------------------
// bcdadd
// Single-digit BCD adder, purely combinational.
//   a, b : BCD digits (values above 9 give results with no meaning)
//   cin  : decimal carry-in
//   sum  : BCD result digit
//   cout : decimal carry-out
// ---------------------------------------------------------------------------
module bcdadd
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] z;

    // A binary sum above 9 is wrapped into the next decade by adding 6 (mod 16).
    always_comb begin
        z    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = z > {1'b0, BCD_MAX};
        sum  = cout ? (z[3:0] + 4'd6) : z[3:0];
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
// Multi-digit BCD adder controller. It shares one bcdadd across DIGITS
// digits, least significant digit first, one digit per clock.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_serial_add_ctrl_if slave
//           (start/a/b/cin in, busy/done/sum/cout/err out)
// Parameters:
//   DIGITS : BCD digits per operand (>= 2); must match the interface's DIGITS
//   CNT_W  : digit counter width, 2**CNT_W > DIGITS
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_serial_add_ctrl_if.slave  bus
);

    localparam int W = 4 * DIGITS;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             last_digit;
    logic             any_invalid;

    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [W-1:0]     sum_sr;
    logic [W-1:0]     sum_next;
    logic             carry_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt;

    logic [W-1:0]     sum_r;
    logic             cout_r;
    logic             err_out_r;

    logic [3:0]       digit_sum;
    logic             digit_carry;

    bcdadd u_bcdadd (
        .a    (a_sr[3:0]),
        .b    (b_sr[3:0]),
        .cin  (carry_r),
        .sum  (digit_sum),
        .cout (digit_carry)
    );

    // The err flag covers every digit of both operands as presented at acceptance.
    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            any_invalid = any_invalid
                        | digit_invalid(bus.a[4*i +: 4])
                        | digit_invalid(bus.b[4*i +: 4]);
        end
    end

    // Each new digit result enters at the MSB end. After DIGITS shifts, digit 0
    // has reached bits [3:0].
    always_comb begin
        sum_next = {digit_sum, {(W-4){1'b0}}} | (sum_sr >> 4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A start request is accepted in IDLE and DONE. In DONE this gives
    // back-to-back operations. A start during ADD is ignored.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last_digit = (cnt == CNT_W'(DIGITS - 1));
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = ADD;
                end
            end
            ADD: begin
                if (last_digit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = ADD;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The visible results are separate registers. They are loaded only on the
    // final digit, so they hold the previous answer while the next one is computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry_r   <= 1'b0;
            err_r     <= 1'b0;
            cnt       <= '0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
            err_out_r <= 1'b0;
        end else if (accept) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            carry_r <= bus.cin;
            err_r   <= any_invalid;
            cnt     <= '0;
        end else if (state == ADD) begin
            a_sr    <= a_sr >> 4;
            b_sr    <= b_sr >> 4;
            sum_sr  <= sum_next;
            carry_r <= digit_carry;
            cnt     <= cnt + 1'b1;
            if (last_digit) begin
                sum_r     <= sum_next;
                cout_r    <= digit_carry;
                err_out_r <= err_r;
            end
        end
    end

    assign bus.busy = (state == ADD);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.err  = err_out_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
// Directed testbench for bcd_serial_add_ctrl (DIGITS=4). When an operation
// is started, its expected result is computed with decimal integer arithmetic
// and placed in a queue. When the DUT raises done, that result is taken from
// the queue and compared with the outputs.
// ---------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc          = 0;
    int   compareCount = 0;
    int   failCount    = 0;
    int   acceptCyc    = 0;
    exp_t expQ[$];

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bcdToInt(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            r = r * 10 + int'(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] intToBcd(input int v);
        logic [W-1:0] r = '0;
        int           t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        int   limit = 1;
        int   total;
        for (int i = 0; i < DIGITS; i++) limit = limit * 10;
        total  = bcdToInt(a) + bcdToInt(b) + int'(cin);
        e.cout = (total >= limit);
        e.sum  = intToBcd(total % limit);
        e.err  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) e.err = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge with the DUT in IDLE or DONE. The task returns
    // at the falling edge just after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        expQ.push_back(model(a, b, cin));
        @(negedge clk);
        bus.start = 1'b0;
        acceptCyc = cyc;
    endtask

    task automatic waitDone(input string tag, output int doneCyc);
        int   waited = 0;
        exp_t e;
        while (!bus.done && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        doneCyc = cyc;
        checkOutput({tag, " done_seen"}, 32'(bus.done), 32'd1);
        if (bus.done) begin
            checkOutput({tag, " latency"}, doneCyc - acceptCyc, DIGITS);
            checkOutput({tag, " queue"}, expQ.size(), 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput({tag, " err"}, 32'(bus.err), 32'(e.err));
                if (!e.err) begin
                    checkOutput({tag, " sum"}, 32'(bus.sum), 32'(e.sum));
                    checkOutput({tag, " cout"}, 32'(bus.cout), 32'(e.cout));
                end
            end
        end
    endtask

    initial begin
        int d0;
        int d1;
        int d2;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset sum",  32'(bus.sum),  32'd0);
        checkOutput("reset cout", 32'(bus.cout), 32'd0);
        checkOutput("reset err",  32'(bus.err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h5678, 1'b0);
        checkOutput("first busy", 32'(bus.busy), 32'd1);
        waitDone("add_1234_5678", d0);
        @(negedge clk);
        checkOutput("done_pulse", 32'(bus.done), 32'd0);
        checkOutput("idle busy",  32'(bus.busy), 32'd0);
        checkOutput("idle hold",  32'(bus.sum),  32'h6912);

        applyStimulus(16'h9999, 16'h0001, 1'b0);
        waitDone("wrap_9999", d0);
        @(negedge clk);

        applyStimulus(16'h0000, 16'h0000, 1'b1);
        waitDone("cin_only", d0);
        @(negedge clk);

        applyStimulus(16'h12A4, 16'h0000, 1'b0);
        waitDone("bad_digit", d0);
        @(negedge clk);

        applyStimulus(16'h0005, 16'h0005, 1'b0);
        waitDone("after_bad", d0);
        @(negedge clk);

        // Back-to-back operations. A start pulse and new operands during ADD
        // must not disturb the operation in flight.
        applyStimulus(16'h1234, 16'h5678, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h4999;
        bus.b     = 16'h5001;
        bus.cin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone("b2b_first", d1);
        bus.start = 1'b1;
        bus.a     = 16'h4999;
        bus.b     = 16'h5001;
        bus.cin   = 1'b0;
        expQ.push_back(model(16'h4999, 16'h5001, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        acceptCyc = cyc;
        checkOutput("b2b busy", 32'(bus.busy), 32'd1);
        checkOutput("b2b hold", 32'(bus.sum),  32'h6912);
        waitDone("b2b_second", d2);
        checkOutput("b2b spacing", d2 - d1, DIGITS + 1);
        @(negedge clk);

        applyStimulus(16'h1111, 16'h2222, 1'b0);
        waitDone("add_3333", d0);
        @(negedge clk);

        // Asynchronous reset in the third ADD cycle
        applyStimulus(16'h1234, 16'h5678, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset done", 32'(bus.done), 32'd0);
        checkOutput("midreset sum",  32'(bus.sum),  32'd0);
        checkOutput("midreset cout", 32'(bus.cout), 32'd0);
        checkOutput("midreset err",  32'(bus.err),  32'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset idle", 32'(bus.busy), 32'd0);

        applyStimulus(16'h1234, 16'h5678, 1'b0);
        waitDone("after_reset", d0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
